// File: rtl/cpu_6502_g1_addr_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_6502_g1_addr_seq_if
//  Description : Start/result handshake and shared memory read port of the
//                group-one addressing-mode sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_6502_g1_addr_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              start;
    logic              start_ready;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] y_reg;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              done;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] operand;
    logic [1:0]        op_len;
    logic              illegal;

    // Core side: issues instructions, serves the memory port, consumes results.
    modport master (
        output start, opcode, pc, x_reg, y_reg, mem_ready, mem_rdata,
        input  start_ready, mem_rd, mem_addr, done, eff_addr, operand, op_len, illegal
    );

    // Sequencer side.
    modport slave (
        input  start, opcode, pc, x_reg, y_reg, mem_ready, mem_rdata,
        output start_ready, mem_rd, mem_addr, done, eff_addr, operand, op_len, illegal
    );
endinterface
`default_nettype wire

// File: rtl/cpu_6502_g1_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_6502_g1_addr_seq
//  Description : 6502 group-one (cc=01) addressing-mode sequencer: fetches
//                operand, pointer and data bytes, returns EA/data/length.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_6502_g1_addr_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    cpu_6502_g1_addr_seq_if.slave        bus
);
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_opl  = 3'd1;
    localparam logic [2:0] c_st_oph  = 3'd2;
    localparam logic [2:0] c_st_ptl  = 3'd3;
    localparam logic [2:0] c_st_pth  = 3'd4;
    localparam logic [2:0] c_st_dat  = 3'd5;
    localparam logic [2:0] c_st_done = 3'd6;

    localparam logic [2:0] c_mode_izx = 3'b000;
    localparam logic [2:0] c_mode_zp  = 3'b001;
    localparam logic [2:0] c_mode_imm = 3'b010;
    localparam logic [2:0] c_mode_izy = 3'b100;
    localparam logic [2:0] c_mode_zpx = 3'b101;
    localparam logic [2:0] c_mode_aby = 3'b110;
    localparam logic [2:0] c_mode_abx = 3'b111;

    localparam logic [ADDR_W-1:0] c_addr_one = 1;
    localparam logic [DATA_W-1:0] c_byte_one = 1;
    localparam logic [ADDR_W-DATA_W-1:0] c_zero_hi = '0;

    logic [2:0]        r_state;
    logic              r_cap;        // 0: request phase, 1: capture phase
    logic [2:0]        r_mode;
    logic              r_sta;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_ea;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_start_ready;
    logic              r_done;
    logic [ADDR_W-1:0] r_eff_addr;
    logic [DATA_W-1:0] r_operand;
    logic [1:0]        r_op_len;
    logic              r_illegal;

    logic [DATA_W-1:0] w_byte;
    logic [DATA_W-1:0] w_zp_idx;
    logic [DATA_W-1:0] w_ptr_inc;
    logic [ADDR_W-1:0] w_base;
    logic [2:0]        w_nxt_state;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [ADDR_W-1:0] w_ea;
    logic [DATA_W-1:0] w_ptr;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_operand;
    logic [1:0]        w_op_len;
    logic              w_illegal;

    assign w_byte    = bus.mem_rdata;
    assign w_zp_idx  = w_byte + r_x;
    assign w_ptr_inc = r_ptr + c_byte_one;
    assign w_base    = {w_byte, r_lo};
    assign w_illegal = (bus.opcode[1:0] != 2'b01) || (bus.opcode == 8'h89);
    assign w_op_len  = (r_mode == 3'b011 || r_mode == c_mode_aby || r_mode == c_mode_abx) ? 2'd2 : 2'd1;
    assign w_operand = (r_state == c_st_dat || (r_state == c_st_opl && r_mode == c_mode_imm)) ? w_byte : '0;

    // Capture-phase decisions: next state, next read address and the working EA.
    always_comb begin
        w_nxt_state = c_st_dat;
        w_nxt_addr  = r_mem_addr;
        w_ea        = r_ea;
        w_ptr       = r_ptr;
        w_lo        = r_lo;
        case (r_state)
            c_st_opl: begin
                case (r_mode)
                    c_mode_imm: begin
                        w_ea        = r_pc;
                        w_nxt_state = c_st_done;
                    end
                    c_mode_zp:  w_ea = {c_zero_hi, w_byte};
                    c_mode_zpx: w_ea = {c_zero_hi, w_zp_idx};
                    c_mode_izx: begin
                        w_ptr       = w_zp_idx;
                        w_nxt_state = c_st_ptl;
                        w_nxt_addr  = {c_zero_hi, w_zp_idx};
                    end
                    c_mode_izy: begin
                        w_ptr       = w_byte;
                        w_nxt_state = c_st_ptl;
                        w_nxt_addr  = {c_zero_hi, w_byte};
                    end
                    default: begin
                        w_lo        = w_byte;
                        w_nxt_state = c_st_oph;
                        w_nxt_addr  = r_pc + c_addr_one;
                    end
                endcase
            end
            c_st_oph: begin
                case (r_mode)
                    c_mode_aby: w_ea = w_base + {c_zero_hi, r_y};
                    c_mode_abx: w_ea = w_base + {c_zero_hi, r_x};
                    default:    w_ea = w_base;
                endcase
            end
            c_st_ptl: begin
                w_lo        = w_byte;
                w_nxt_state = c_st_pth;
                w_nxt_addr  = {c_zero_hi, w_ptr_inc};
            end
            c_st_pth: w_ea = (r_mode == c_mode_izy) ? w_base + {c_zero_hi, r_y} : w_base;
            default:  w_nxt_state = c_st_done;
        endcase
        // Stores have their address once the EA is known; they never read data.
        if (w_nxt_state == c_st_dat) begin
            if (r_sta) begin
                w_nxt_state = c_st_done;
            end else begin
                w_nxt_addr = w_ea;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cap         <= 1'b0;
            r_mode        <= '0;
            r_sta         <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_pc          <= '0;
            r_lo          <= '0;
            r_ptr         <= '0;
            r_ea          <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_start_ready <= 1'b1;
            r_done        <= 1'b0;
            r_eff_addr    <= '0;
            r_operand     <= '0;
            r_op_len      <= '0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_start_ready <= 1'b0;
                        r_mode        <= bus.opcode[4:2];
                        r_sta         <= (bus.opcode[7:5] == 3'b100);
                        r_x           <= bus.x_reg;
                        r_y           <= bus.y_reg;
                        r_pc          <= bus.pc;
                        r_cap         <= 1'b0;
                        if (w_illegal) begin
                            r_state    <= c_st_done;
                            r_done     <= 1'b1;
                            r_illegal  <= 1'b1;
                            r_op_len   <= 2'd0;
                            r_eff_addr <= '0;
                            r_operand  <= '0;
                        end else begin
                            r_state    <= c_st_opl;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= bus.pc;
                        end
                    end
                end
                c_st_done: begin
                    r_done        <= 1'b0;
                    r_state       <= c_st_idle;
                    r_start_ready <= 1'b1;
                end
                default: begin
                    if (!r_cap) begin
                        if (bus.mem_ready) begin
                            r_mem_rd <= 1'b0;
                            r_cap    <= 1'b1;
                        end
                    end else begin
                        r_cap      <= 1'b0;
                        r_state    <= w_nxt_state;
                        r_mem_addr <= w_nxt_addr;
                        r_ea       <= w_ea;
                        r_ptr      <= w_ptr;
                        r_lo       <= w_lo;
                        if (w_nxt_state == c_st_done) begin
                            r_done     <= 1'b1;
                            r_eff_addr <= w_ea;
                            r_operand  <= w_operand;
                            r_op_len   <= w_op_len;
                            r_illegal  <= 1'b0;
                        end else begin
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.done        = r_done;
    assign bus.eff_addr    = r_eff_addr;
    assign bus.operand     = r_operand;
    assign bus.op_len      = r_op_len;
    assign bus.illegal     = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_cpu_6502_g1_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_6502_g1_addr_seq
//  Description : Directed self-checking bench for the group-one sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_6502_g1_addr_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q[$];
    logic [15:0] req_q[$];
    int          stall_left = 0;
    logic [15:0] stall_addr = 16'h0000;

    cpu_6502_g1_addr_seq_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    cpu_6502_g1_addr_seq #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.mem_ready = !(stall_left > 0 && bus.mem_rd && bus.mem_addr == stall_addr);

    // Memory model: data appears the cycle after the request is accepted.
    always @(posedge clk) begin
        if (bus.mem_rd) req_q.push_back(bus.mem_addr);
        if (bus.mem_rd && !bus.mem_ready) stall_left <= stall_left - 1;
        if (bus.mem_rd && bus.mem_ready) begin
            rd_q.push_back(bus.mem_addr);
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic run_instr(input logic [7:0] opc, input logic [15:0] pcv,
                             input logic [7:0] xv, input logic [7:0] yv,
                             input bit poke, output int lat);
        rd_q.delete();
        req_q.delete();
        bus.start  = 1'b1;
        bus.opcode = opc;
        bus.pc     = pcv;
        bus.x_reg  = xv;
        bus.y_reg  = yv;
        @(posedge clk); #1;
        lat = 1;
        if (poke) begin
            bus.opcode = 8'hA2;
            bus.pc     = 16'hDEAD;
            bus.x_reg  = 8'hEE;
            bus.y_reg  = 8'hEE;
        end else begin
            bus.start = 1'b0;
        end
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        if (lat >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout opcode=%02h no done within %0d cycles", opc, lat);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b rd=%b addr=%04h done=%b want 1 0 0000 0",
                     bus.start_ready, bus.mem_rd, bus.mem_addr, bus.done);
        end
        checks++;
        if (bus.eff_addr !== 16'h0000 || bus.operand !== 8'h00 || bus.op_len !== 2'd0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_result got ea=%04h op=%02h len=%0d ill=%b want 0000 00 0 0",
                     bus.eff_addr, bus.operand, bus.op_len, bus.illegal);
        end
    endtask

    task automatic test_imm;
        int lat;
        mem[16'h0200] = 8'h42;
        run_instr(8'hA9, 16'h0200, 8'h00, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL imm_latency got %0d want 3", lat); end
        checks++;
        if (bus.operand !== 8'h42 || bus.eff_addr !== 16'h0200 || bus.op_len !== 2'd1 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL imm_result got op=%02h ea=%04h len=%0d ill=%b want 42 0200 1 0",
                     bus.operand, bus.eff_addr, bus.op_len, bus.illegal);
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 16'h0200) begin
            errors++;
            $display("FAIL imm_reads got n=%0d first=%04h want n=1 0200", rd_q.size(), rd_q.size() > 0 ? rd_q[0] : 16'hxxxx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zpx;
        int lat;
        mem[16'h0300] = 8'hF0;
        mem[16'h0010] = 8'h5A;
        run_instr(8'hB5, 16'h0300, 8'h20, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL zpx_latency got %0d want 5", lat); end
        checks++;
        if (bus.eff_addr !== 16'h0010 || bus.operand !== 8'h5A || bus.op_len !== 2'd1) begin
            errors++;
            $display("FAIL zpx_result got ea=%04h op=%02h len=%0d want 0010 5A 1", bus.eff_addr, bus.operand, bus.op_len);
        end
        checks++;
        if (rd_q.size() != 2 || rd_q[0] !== 16'h0300 || rd_q[1] !== 16'h0010) begin
            errors++;
            $display("FAIL zpx_reads got n=%0d want 0300,0010", rd_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_indx;
        int lat;
        mem[16'h0400] = 8'hFF;
        mem[16'h00FF] = 8'h34;
        mem[16'h0000] = 8'h12;
        mem[16'h1234] = 8'h77;
        run_instr(8'h61, 16'h0400, 8'h00, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL indx_latency got %0d want 9", lat); end
        checks++;
        if (bus.eff_addr !== 16'h1234 || bus.operand !== 8'h77 || bus.op_len !== 2'd1) begin
            errors++;
            $display("FAIL indx_result got ea=%04h op=%02h len=%0d want 1234 77 1", bus.eff_addr, bus.operand, bus.op_len);
        end
        checks++;
        if (rd_q.size() != 4 || rd_q[1] !== 16'h00FF || rd_q[2] !== 16'h0000 || rd_q[3] !== 16'h1234) begin
            errors++;
            $display("FAIL indx_reads got n=%0d want 0400,00FF,0000,1234", rd_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_indy;
        int lat;
        mem[16'h0500] = 8'h10;
        mem[16'h0010] = 8'hFF;
        mem[16'h0011] = 8'h12;
        mem[16'h1300] = 8'h99;
        // Y is changed right after accept and must be ignored.
        bus.start  = 1'b1;
        bus.opcode = 8'hD1;
        bus.pc     = 16'h0500;
        bus.x_reg  = 8'h00;
        bus.y_reg  = 8'h01;
        rd_q.delete();
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.y_reg = 8'h80;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL indy_latency got %0d want 9", lat); end
        checks++;
        if (bus.eff_addr !== 16'h1300 || bus.operand !== 8'h99) begin
            errors++;
            $display("FAIL indy_result got ea=%04h op=%02h want 1300 99", bus.eff_addr, bus.operand);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abs_wrap;
        int lat;
        mem[16'h0600] = 8'hFF;
        mem[16'h0601] = 8'hFF;
        mem[16'h0001] = 8'h3C;
        run_instr(8'h1D, 16'h0600, 8'h02, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 7 || bus.eff_addr !== 16'h0001 || bus.operand !== 8'h3C || bus.op_len !== 2'd2) begin
            errors++;
            $display("FAIL absx_wrap got lat=%0d ea=%04h op=%02h len=%0d want 7 0001 3C 2",
                     lat, bus.eff_addr, bus.operand, bus.op_len);
        end
        @(posedge clk); #1;
        // abs,Y at pc=FFFF: high operand byte comes from 0000, and the index crosses a page.
        mem[16'hFFFF] = 8'hF0;
        mem[16'h0000] = 8'h12;
        mem[16'h1310] = 8'hAB;
        run_instr(8'hB9, 16'hFFFF, 8'h00, 8'h20, 1'b0, lat);
        checks++;
        if (lat !== 7 || bus.eff_addr !== 16'h1310 || bus.operand !== 8'hAB || bus.op_len !== 2'd2) begin
            errors++;
            $display("FAIL aby_pcwrap got lat=%0d ea=%04h op=%02h len=%0d want 7 1310 AB 2",
                     lat, bus.eff_addr, bus.operand, bus.op_len);
        end
        checks++;
        if (rd_q.size() != 3 || rd_q[1] !== 16'h0000 || rd_q[2] !== 16'h1310) begin
            errors++;
            $display("FAIL aby_reads got n=%0d want FFFF,0000,1310", rd_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sta_stall;
        int lat;
        int n_oph;
        mem[16'h0700] = 8'h34;
        mem[16'h0701] = 8'h12;
        stall_addr = 16'h0701;
        stall_left = 3;
        run_instr(8'h8D, 16'h0700, 8'h00, 8'h00, 1'b1, lat);
        n_oph = 0;
        foreach (req_q[i]) if (req_q[i] == 16'h0701) n_oph++;
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL sta_latency got %0d want 8", lat); end
        checks++;
        if (bus.eff_addr !== 16'h1234 || bus.operand !== 8'h00 || bus.op_len !== 2'd2 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL sta_result got ea=%04h op=%02h len=%0d ill=%b want 1234 00 2 0",
                     bus.eff_addr, bus.operand, bus.op_len, bus.illegal);
        end
        checks++;
        if (rd_q.size() != 2 || req_q.size() != 5 || n_oph != 4) begin
            errors++;
            $display("FAIL sta_bus got reads=%0d reqs=%0d oph_reqs=%0d want 2 5 4", rd_q.size(), req_q.size(), n_oph);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.done !== 1'b0 || bus.eff_addr !== 16'h1234) begin
            errors++;
            $display("FAIL sta_hold got rdy=%b done=%b ea=%04h want 1 0 1234", bus.start_ready, bus.done, bus.eff_addr);
        end
    endtask

    task automatic test_illegal;
        int lat;
        logic [7:0] opcs [2];
        opcs[0] = 8'hA2;
        opcs[1] = 8'h89;
        for (int k = 0; k < 2; k++) begin
            run_instr(opcs[k], 16'h0800, 8'h00, 8'h00, 1'b0, lat);
            checks++;
            if (lat !== 1 || bus.illegal !== 1'b1 || bus.op_len !== 2'd0 || req_q.size() != 0) begin
                errors++;
                $display("FAIL illegal_%02h got lat=%0d ill=%b len=%0d reqs=%0d want 1 1 0 0",
                         opcs[k], lat, bus.illegal, bus.op_len, req_q.size());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        bit done_seen;
        bus.start  = 1'b1;
        bus.opcode = 8'h61;
        bus.pc     = 16'h0400;
        bus.x_reg  = 8'h00;
        bus.y_reg  = 8'h00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h00FF) begin
            errors++;
            $display("FAIL rstmid_ptl got rd=%b addr=%04h want 1 00FF", bus.mem_rd, bus.mem_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_rd !== 1'b0 || bus.start_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got rd=%b rdy=%b done=%b want 0 1 0", bus.mem_rd, bus.start_ready, bus.done);
        end
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.mem_rd === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL rstmid_quiet got activity=1 want 0");
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        bus.start     = 1'b0;
        bus.opcode    = 8'h00;
        bus.pc        = 16'h0000;
        bus.x_reg     = 8'h00;
        bus.y_reg     = 8'h00;
        bus.mem_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_imm();
        test_zpx();
        test_indx();
        test_indy();
        test_abs_wrap();
        test_sta_stall();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_6502_g1_addr_seq.md
Name: cpu_6502_g1_addr_seq

Overview:
Addressing-mode sequencer for group-one instructions (cc=01: ORA, AND, EOR, ADC, STA, LDA, CMP, SBC).
- Decoder hands over the fetched opcode and the PC of the first operand byte.
- Block issues the operand, pointer and data reads over the shared memory port, using the X/Y register values.
- Returns the effective address, the fetched data byte and the instruction length.
- Sits between FETCH and the ALU; the core control FSM holds the memory port for it while busy.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, data / register width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request to sequence one instruction; accepted only when start_ready=1
start_ready  out  1  high only in IDLE
opcode  in  8  opcode byte, sampled on accept
pc  in  16  address of first operand byte, sampled on accept
x_reg  in  8  X value, sampled on accept
y_reg  in  8  Y value, sampled on accept
mem_rd  out  1  read request
mem_addr  out  16  read address, valid while mem_rd=1
mem_ready  in  1  memory accepts the request this cycle
mem_rdata  in  8  read data, valid the cycle after acceptance
done  out  1  one-cycle pulse: outputs below are valid
eff_addr  out  16  effective address (IMM: address of immediate byte)
operand  out  8  data byte read (IMM: immediate; STA: 0)
op_len  out  2  operand bytes after opcode (1 or 2), for PC update
illegal  out  1  with done: opcode not handled

Behaviour:
- Reset values: start_ready=1, mem_rd=0, mem_addr=0, done=0, eff_addr=0, operand=0, op_len=0, illegal=0. Reset mid-sequence returns to IDLE next cycle; mem_rd=0 from that cycle; no done pulse.
- Mode field is opcode[4:2]:
  - 000 (zp,X)
  - 001 zp
  - 010 #imm
  - 011 abs
  - 100 (zp),Y
  - 101 zp,X
  - 110 abs,Y
  - 111 abs,X
- Illegal opcodes: opcode[1:0]!=01, or 0x89 (STA #imm). One cycle after accept: done=1, illegal=1, op_len=0, no memory access.
- States: IDLE, OPL, OPH, PTL, PTH, DAT, DONE.
- Every access state has two phases:
  - REQ: mem_rd=1, held with a stable address until mem_ready=1.
  - CAP: mem_rd=0, mem_rdata captured.
  - Minimum 2 cycles per access.
- State sequences:
  - IMM: OPL(pc) -> DONE
  - zp, zp,X: OPL(pc) -> DAT
  - abs, abs,X/Y: OPL(pc) -> OPH(pc+1) -> DAT
  - (zp,X): OPL(pc) -> PTL((zp+X)&FF) -> PTH((zp+X+1)&FF) -> DAT
  - (zp),Y: OPL(pc) -> PTL(zp) -> PTH((zp+1)&FF) -> DAT
  - STA skips DAT and goes directly to DONE.
- Address arithmetic:
  - Zero-page indexing and pointer fetch wrap modulo 256; the high byte is always 00.
  - abs,X / abs,Y / (zp),Y add the zero-extended index to the 16-bit base, wrapping modulo 65536.
  - Page crossing adds no cycles.
  - pc+1 wraps FFFF->0000.
- Latency: with mem_ready held high and accept at cycle T, done is asserted at T+1+2A. A = number of accesses:
  - IMM: 1
  - zp, zp,X: 2
  - abs, abs,X/Y: 3
  - indirect modes: 4
  - STA: one fewer than the corresponding load mode.
  - Each stalled REQ cycle adds 1.
- DONE lasts one cycle, then IDLE. start_ready=1 in the IDLE cycle after DONE; start during DONE is ignored.
- eff_addr, operand, op_len and illegal hold their values until the next done.
- op_len: 1 for IMM, zp, zp,X and the indirect modes; 2 for the abs modes.
- start while busy: ignored. x_reg/y_reg changes after accept: ignored.

Test Plan:
- LDA #$42 (A9), pc=0200, mem[0200]=42, ready=1 -> one read at 0200; done at T+3, operand=42, eff_addr=0200, op_len=1.
- LDA $F0,X (B5), X=20, mem[0300]=F0, mem[0010]=5A, pc=0300 -> reads 0300 then 0010; done T+5, eff_addr=0010, operand=5A.
- ADC ($FF,X) (61), X=00, mem[00FF]=34, mem[0000]=12, mem[1234]=77 -> pointer reads at 00FF then 0000; done T+9, eff_addr=1234, operand=77.
- CMP ($10),Y (D1), mem[0010]=FF, mem[0011]=12, Y=01 -> eff_addr=1300; ORA abs,X (1D) base FFFF, X=02 -> eff_addr=0001, op_len=2.
- STA $1234 (8D) with mem_ready low for 3 cycles on OPH -> mem_addr held at pc+1 for all stall cycles; no data read; done T+8, eff_addr=1234, operand=00.
- Opcode A2 and opcode 89 -> done at T+1 with illegal=1, no mem_rd. Separately, rst asserted during PTL -> next cycle mem_rd=0 and start_ready=1, with no done pulse.
